// File: rtl/seg7_display_driver_pkg.sv
// seg7_display_driver_pkg: segment codes, digit count and field limits shared by the display driver.
package seg7_display_driver_pkg;
  localparam int NUM_DIGITS = 6;
  localparam logic [5:0] HR_MAX = 6'd23;
  localparam logic [5:0] MS_MAX = 6'd59;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0: seg_encode = SEG_0;
      4'd1: seg_encode = SEG_1;
      4'd2: seg_encode = SEG_2;
      4'd3: seg_encode = SEG_3;
      4'd4: seg_encode = SEG_4;
      4'd5: seg_encode = SEG_5;
      4'd6: seg_encode = SEG_6;
      4'd7: seg_encode = SEG_7;
      4'd8: seg_encode = SEG_8;
      4'd9: seg_encode = SEG_9;
      default: seg_encode = SEG_OFF;
    endcase
  endfunction
endpackage

// File: rtl/seg7_display_driver_bin2bcd_pair.sv
// seg7_display_driver_bin2bcd_pair: 6-bit binary to two BCD digits with an out-of-range flag.
module seg7_display_driver_bin2bcd_pair #(
  parameter logic [5:0] MAX = 6'd59
) (
  input  logic [5:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       oor_o
);
  logic [5:0] r40, r20, r10;
  // Restoring subtraction of 40/20/10 yields the tens bits directly for inputs up to 63
  always_comb begin
    r40 = bin_i >= 6'd40 ? bin_i - 6'd40 : bin_i;
    r20 = r40 >= 6'd20 ? r40 - 6'd20 : r40;
    r10 = r20 >= 6'd10 ? r20 - 6'd10 : r20;
    tens_o = {1'b0, bin_i >= 6'd40, r40 >= 6'd20, r20 >= 6'd10};
    ones_o = 4'(r10);
    oor_o = bin_i > MAX;
  end
endmodule

// File: rtl/seg7_display_driver.sv
// seg7_display_driver: scans hr/min/sec onto a 6-digit common-anode display and drives a blinking alert buzzer.
module seg7_display_driver
  import seg7_display_driver_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int BLINK_DIV = 16,
  parameter int BUZZ_LEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hr,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       alarm_flag,
  input  logic       timer_done,
  input  logic       ack,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       buzzer
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int LW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam int BW = BUZZ_LEN > 1 ? $clog2(BUZZ_LEN) : 1;

  logic [SW-1:0] scan_q;
  logic [LW-1:0] blink_q;
  logic [BW-1:0] buzz_cnt_q;
  logic [2:0]    idx_q;
  logic [4:0]    snap_hr_q;
  logic [5:0]    snap_min_q, snap_sec_q;
  logic          phase_q, prev_alarm_q, prev_timer_q, buzzer_q;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick, blink_end, frame_start, ev, pair_oor;
  logic [4:0]    cur_hr;
  logic [5:0]    cur_min, cur_sec;
  logic [3:0]    hr_t, hr_o, min_t, min_o, sec_t, sec_o, digit;
  logic          hr_oor, min_oor, sec_oor;

  assign tick = scan_q == SW'(SCAN_DIV - 1);
  assign blink_end = blink_q == LW'(BLINK_DIV - 1);
  assign frame_start = idx_q == 3'd0;
  assign ev = (alarm_flag & ~prev_alarm_q) | (timer_done & ~prev_timer_q);

  // Digit 0 shows the live inputs on the very edge the snapshot is taken
  assign cur_hr = frame_start ? hr : snap_hr_q;
  assign cur_min = frame_start ? min : snap_min_q;
  assign cur_sec = frame_start ? sec : snap_sec_q;

  seg7_display_driver_bin2bcd_pair #(.MAX(HR_MAX)) u_hr (
    .bin_i({1'b0, cur_hr}), .tens_o(hr_t), .ones_o(hr_o), .oor_o(hr_oor));
  seg7_display_driver_bin2bcd_pair #(.MAX(MS_MAX)) u_min (
    .bin_i(cur_min), .tens_o(min_t), .ones_o(min_o), .oor_o(min_oor));
  seg7_display_driver_bin2bcd_pair #(.MAX(MS_MAX)) u_sec (
    .bin_i(cur_sec), .tens_o(sec_t), .ones_o(sec_o), .oor_o(sec_oor));

  always_comb begin
    pair_oor = idx_q[2] ? hr_oor : idx_q[1] ? min_oor : sec_oor;
    digit = idx_q == 3'd0 ? sec_o :
            idx_q == 3'd1 ? sec_t :
            idx_q == 3'd2 ? min_o :
            idx_q == 3'd3 ? min_t :
            idx_q == 3'd4 ? hr_o : hr_t;
    seg_d = pair_oor ? SEG_DASH : seg_encode(digit);
    an_d = (buzzer_q && !phase_q) ? 6'b111111 : ~(6'b000001 << idx_q);
    dp_d = !(idx_q == 3'd2 || idx_q == 3'd4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q <= '0;
      blink_q <= '0;
      phase_q <= 1'b1;
      idx_q <= '0;
      snap_hr_q <= '0;
      snap_min_q <= '0;
      snap_sec_q <= '0;
      prev_alarm_q <= 1'b0;
      prev_timer_q <= 1'b0;
      buzzer_q <= 1'b0;
      buzz_cnt_q <= '0;
      an_q <= 6'b111111;
      seg_q <= SEG_OFF;
      dp_q <= 1'b1;
    end else begin
      scan_q <= tick ? '0 : scan_q + 1'b1;
      blink_q <= blink_end ? '0 : blink_q + 1'b1;
      phase_q <= phase_q ^ blink_end;
      prev_alarm_q <= alarm_flag;
      prev_timer_q <= timer_done;
      if (ack) begin
        buzzer_q <= 1'b0;
      end else if (ev) begin
        buzzer_q <= 1'b1;
        buzz_cnt_q <= BW'(BUZZ_LEN - 1);
      end else if (buzzer_q) begin
        if (buzz_cnt_q == '0) buzzer_q <= 1'b0;
        else buzz_cnt_q <= buzz_cnt_q - 1'b1;
      end
      if (tick) begin
        idx_q <= idx_q == 3'(NUM_DIGITS - 1) ? 3'd0 : idx_q + 3'd1;
        an_q <= an_d;
        seg_q <= seg_d;
        dp_q <= dp_d;
        if (frame_start) begin
          snap_hr_q <= hr;
          snap_min_q <= min;
          snap_sec_q <= sec;
        end
      end
    end
  end

  assign an = an_q;
  assign seg = seg_q;
  assign dp = dp_q;
  assign buzzer = buzzer_q;
endmodule

// File: tb/tb_seg7_display_driver.sv
// tb_seg7_display_driver: randomized scoreboard bench against a frame-level model of the display driver.
module tb_seg7_display_driver;
  localparam int SCAN_DIV = 4;
  localparam int BLINK_DIV = 16;
  localparam int BUZZ_LEN = 64;
  localparam logic [6:0] CODES [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] DASH = 7'b0111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] hr = 5'd13;
  logic [5:0] min = 6'd45;
  logic [5:0] sec = 6'd7;
  logic alarm_flag = 1'b0;
  logic timer_done = 1'b0;
  logic ack = 1'b0;
  logic [5:0] an;
  logic [6:0] seg;
  logic dp, buzzer;
  int checks = 0;
  int errors = 0;

  seg7_display_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .BUZZ_LEN(BUZZ_LEN)) dut (
    .clk(clk), .rst(rst), .hr(hr), .min(min), .sec(sec), .alarm_flag(alarm_flag),
    .timer_done(timer_done), .ack(ack), .an(an), .seg(seg), .dp(dp), .buzzer(buzzer));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {logic [5:0] an; logic [6:0] seg; logic dp;} out_t;
  out_t oq[$];
  logic bq[$];
  out_t exp_o;
  int n, m_idx, buzz_left, s_hr, s_min, s_sec, v, lim;
  logic prev_a, prev_t;

  // Reference: whole-frame snapshot, digit = v%10 / v/10, buzzer as a remaining-clocks count
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; m_idx = 0; buzz_left = 0; prev_a = 0; prev_t = 0;
      s_hr = 0; s_min = 0; s_sec = 0;
      oq.delete(); bq.delete();
    end else begin
      if (n % SCAN_DIV == SCAN_DIV - 1) begin
        if (m_idx == 0) begin s_hr = int'(hr); s_min = int'(min); s_sec = int'(sec); end
        v = m_idx < 2 ? s_sec : m_idx < 4 ? s_min : s_hr;
        lim = m_idx < 4 ? 59 : 23;
        exp_o.seg = v > lim ? DASH : CODES[(m_idx % 2 == 1) ? v / 10 : v % 10];
        exp_o.dp = !(m_idx == 2 || m_idx == 4);
        exp_o.an = (buzz_left > 0 && (n / BLINK_DIV) % 2 == 1) ? 6'b111111 : ~(6'b000001 << m_idx);
        oq.push_back(exp_o);
        m_idx = (m_idx + 1) % 6;
      end
      if (ack) buzz_left = 0;
      else if ((alarm_flag && !prev_a) || (timer_done && !prev_t)) buzz_left = BUZZ_LEN;
      else if (buzz_left > 0) buzz_left--;
      prev_a = alarm_flag;
      prev_t = timer_done;
      bq.push_back(buzz_left > 0);
      n++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (oq.size() > 0) check("digit_out", {18'd0, an, seg, dp}, {18'd0, oq.pop_front()});
      if (bq.size() > 0) check("buzzer", {31'd0, buzzer}, {31'd0, bq.pop_front()});
    end
  end

  task automatic wait_an(input logic [5:0] target, input logic [6:0] exp_seg, input string name);
    int k = 0;
    while (an !== target && k < 60) begin @(negedge clk); k++; end
    if (an !== target) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for an=%b, last an=%b", name, target, an);
    end else check(name, {25'd0, seg}, {25'd0, exp_seg});
  endtask

  initial begin
    int hi, blank_seen, k;
    repeat (3) @(negedge clk);
    check("rst_an", {26'd0, an}, 32'h3f);
    check("rst_seg", {25'd0, seg}, 32'h7f);
    check("rst_dp", {31'd0, dp}, 32'd1);
    check("rst_buzzer", {31'd0, buzzer}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("first_an", {26'd0, an}, 32'h3e);
    check("first_seg", {25'd0, seg}, {25'd0, CODES[7]});
    repeat (48) @(negedge clk);
    k = 0;
    while (m_idx != 3 && k < 30) begin @(negedge clk); k++; end
    hr = 5'd2; min = 6'd0; sec = 6'd0;
    wait_an(6'b101111, CODES[3], "torn_hr_ones");
    wait_an(6'b011111, CODES[1], "torn_hr_tens");
    wait_an(6'b111110, CODES[0], "new_sec_ones");
    wait_an(6'b101111, CODES[2], "new_hr_ones");
    wait_an(6'b011111, CODES[0], "new_hr_tens");
    hr = 5'd23; min = 6'd61; sec = 6'd59;
    repeat (30) @(negedge clk);
    wait_an(6'b111011, DASH, "dash_min_ones");
    wait_an(6'b110111, DASH, "dash_min_tens");
    wait_an(6'b101111, CODES[3], "hr23_ones");
    wait_an(6'b011111, CODES[2], "hr23_tens");
    wait_an(6'b111110, CODES[9], "sec59_ones");
    for (int i = 0; i < 40; i++) begin
      hr = 5'($urandom_range(0, 31));
      min = 6'($urandom_range(0, 63));
      sec = 6'($urandom_range(0, 63));
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    hr = 5'd13; min = 6'd45; sec = 6'd7;
    alarm_flag = 1'b1;
    hi = 0; blank_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) check("buzz_start", {31'd0, buzzer}, 32'd1);
      hi += int'(buzzer);
      if (an == 6'b111111) blank_seen++;
    end
    check("buzz_len", hi, BUZZ_LEN);
    check("blank_seen", {31'd0, blank_seen > 0}, 32'd1);
    alarm_flag = 1'b0;
    @(negedge clk);
    alarm_flag = 1'b1;
    repeat (10) @(negedge clk);
    ack = 1'b1; timer_done = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_priority", {31'd0, buzzer}, 32'd0);
    repeat (5) @(negedge clk);
    check("no_retrigger", {31'd0, buzzer}, 32'd0);
    alarm_flag = 1'b0; timer_done = 1'b0;
    @(negedge clk);
    alarm_flag = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_buzzer", {31'd0, buzzer}, 32'd0);
    check("arst_an", {26'd0, an}, 32'h3f);
    check("arst_seg", {25'd0, seg}, 32'h7f);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
